// File: rtl/vga_pkg.sv
// Shared types, constants and font content for the text-mode VGA read path.
package vga_pkg;

    localparam int unsigned CHAR_W     = 8;
    localparam int unsigned CHAR_H     = 16;
    localparam int unsigned TEXT_COLS  = 80;
    localparam int unsigned TEXT_ROWS  = 30;
    localparam int unsigned PIPE_DEPTH = 3;

    localparam int unsigned DEF_H_VISIBLE = 640;
    localparam int unsigned DEF_H_FRONT   = 16;
    localparam int unsigned DEF_H_SYNC    = 96;
    localparam int unsigned DEF_H_BACK    = 48;
    localparam int unsigned DEF_V_VISIBLE = 480;
    localparam int unsigned DEF_V_FRONT   = 10;
    localparam int unsigned DEF_V_SYNC    = 2;
    localparam int unsigned DEF_V_BACK    = 33;

    typedef logic [11:0] rgb444_t;

    // Per-pixel control bits that travel down the pipeline alongside the fetch.
    typedef struct packed {
        logic       vis;
        logic       hs_n;
        logic       vs_n;
        logic       fs;
        logic [2:0] hbit;
    } pix_ctl_t;

    localparam pix_ctl_t PIX_CTL_RESET = '{vis: 1'b0, hs_n: 1'b1, vs_n: 1'b1,
                                           fs: 1'b0, hbit: 3'd0};

    // Glyph line for a character code: 'A' carries a real glyph, every other
    // code gets a code-dependent fill so neighbouring cells are distinguishable.
    function automatic logic [7:0] font_glyph(input logic [7:0] code,
                                              input logic [3:0] line);
        logic [7:0] glyph;
        glyph = code + {line, line};
        if (code == 8'h41) begin
            case (line)
                4'd0:    glyph = 8'h18;
                4'd1:    glyph = 8'h3C;
                4'd2:    glyph = 8'h66;
                4'd3:    glyph = 8'h66;
                4'd4:    glyph = 8'h7E;
                4'd5:    glyph = 8'h66;
                4'd6:    glyph = 8'h66;
                4'd7:    glyph = 8'h66;
                default: glyph = 8'h00;
            endcase
        end
        return glyph;
    endfunction

endpackage

// File: rtl/vga_text_reader_font_rom.sv
// Font ROM: 4096x8 glyph storage addressed by {char, line}, registered read.
module font_rom
    import vga_pkg::*;
(
    input  logic        clk,
    input  logic [11:0] i_addr,
    output logic [7:0]  o_data
);

    // One-cycle registered glyph lookup.
    always_ff @(posedge clk) begin
        o_data <= font_glyph(i_addr[11:4], i_addr[3:0]);
    end

endmodule

// File: rtl/vga_text_reader.sv
// VGA text-mode reader: 640x480@60 timing, VRAM fetch, font expansion to RGB444.
// Optional blinking underline cursor enabled by defining VGA_TEXT_CURSOR_EN.
module vga_text_reader
    import vga_pkg::*;
#(
    parameter int unsigned READ_ADDR_SIZE = 12,
    parameter int unsigned H_VISIBLE      = DEF_H_VISIBLE,
    parameter int unsigned H_FRONT        = DEF_H_FRONT,
    parameter int unsigned H_SYNC         = DEF_H_SYNC,
    parameter int unsigned H_BACK         = DEF_H_BACK,
    parameter int unsigned V_VISIBLE      = DEF_V_VISIBLE,
    parameter int unsigned V_FRONT        = DEF_V_FRONT,
    parameter int unsigned V_SYNC         = DEF_V_SYNC,
    parameter int unsigned V_BACK         = DEF_V_BACK,
    parameter rgb444_t     FG_COLOR       = 12'hFFF,
    parameter rgb444_t     BG_COLOR       = 12'h000
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic [READ_ADDR_SIZE-1:0] vram_read_address,
    input  logic [7:0]                r_data,
    output logic                      hsync,
    output logic                      vsync,
    output logic                      de,
    output logic [11:0]               rgb,
    output logic                      frame_start
`ifdef VGA_TEXT_CURSOR_EN
    ,
    input  logic [6:0]                cursor_col,
    input  logic [4:0]                cursor_row
`endif
);

    localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    logic [9:0]                r_h_cnt, r_v_cnt;
    logic                      w_h_last, w_v_last, w_vis0;
    pix_ctl_t                  w_ctl0, r_ctl1, r_ctl2;
    logic [3:0]                r_line1;
    logic [READ_ADDR_SIZE-1:0] r_vram_addr;
    logic [7:0]                w_font;
    logic                      w_bit, w_inv;
    rgb444_t                   w_rgb, r_rgb;
    logic                      r_hsync, r_vsync, r_de, r_frame_start;

    assign w_h_last = (r_h_cnt == 10'(H_TOTAL - 1));
    assign w_v_last = (r_v_cnt == 10'(V_TOTAL - 1));
    assign w_vis0   = (r_h_cnt < 10'(H_VISIBLE)) && (r_v_cnt < 10'(V_VISIBLE));

    assign w_ctl0.vis  = w_vis0;
    assign w_ctl0.hs_n = !((r_h_cnt >= 10'(HS_START)) && (r_h_cnt < 10'(HS_END)));
    assign w_ctl0.vs_n = !((r_v_cnt >= 10'(VS_START)) && (r_v_cnt < 10'(VS_END)));
    assign w_ctl0.fs   = (r_h_cnt == '0) && (r_v_cnt == '0);
    assign w_ctl0.hbit = r_h_cnt[2:0];

    // Raster position counters; vertical advances on horizontal wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_last ? '0 : r_v_cnt + 10'd1;
        end else begin
            r_h_cnt <= r_h_cnt + 10'd1;
        end
    end

    // Stage 0: issue the VRAM cell address and launch the control bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vram_addr <= '0;
            r_ctl1      <= PIX_CTL_RESET;
            r_line1     <= '0;
        end else begin
            r_vram_addr <= w_vis0 ? READ_ADDR_SIZE'({r_v_cnt[8:4], r_h_cnt[9:3]}) : '0;
            r_ctl1      <= w_ctl0;
            r_line1     <= r_v_cnt[3:0];
        end
    end

    assign vram_read_address = r_vram_addr;

    font_rom u_font_rom (
        .clk    (clk),
        .i_addr ({r_data, r_line1}),
        .o_data (w_font)
    );

    // Stage 1: control bits wait alongside the font ROM read.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctl2 <= PIX_CTL_RESET;
        end else begin
            r_ctl2 <= r_ctl1;
        end
    end

`ifdef VGA_TEXT_CURSOR_EN
    logic       w_cur0, r_cur1, r_cur2;
    logic [5:0] r_frame_cnt;

    assign w_cur0 = w_vis0 && (r_v_cnt[8:4] == cursor_row) &&
                    (r_h_cnt[9:3] == cursor_col) && (r_v_cnt[3:1] == 3'b111);

    // Cursor-cell flag follows the pixel pipeline; blink counter counts frames.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur1      <= 1'b0;
            r_cur2      <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_cur1 <= w_cur0;
            r_cur2 <= r_cur1;
            if (r_frame_start) begin
                r_frame_cnt <= r_frame_cnt + 6'd1;
            end
        end
    end

    assign w_inv = r_cur2 & r_frame_cnt[5];
`else
    assign w_inv = 1'b0;
`endif

    // Stage 2 pixel select: bit 7 of the glyph byte is the leftmost pixel.
    always_comb begin
        w_bit = w_font[3'd7 - r_ctl2.hbit] ^ w_inv;
        w_rgb = '0;
        if (r_ctl2.vis) begin
            w_rgb = w_bit ? FG_COLOR : BG_COLOR;
        end
    end

    // Stage 2: register colour, syncs, enable and frame pulse together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rgb         <= '0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_de          <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_rgb         <= w_rgb;
            r_hsync       <= r_ctl2.hs_n;
            r_vsync       <= r_ctl2.vs_n;
            r_de          <= r_ctl2.vis;
            r_frame_start <= r_ctl2.fs;
        end
    end

    assign rgb         = r_rgb;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign de          = r_de;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_text_reader.sv
// Self-checking bench for vga_text_reader using reduced raster timing.
module tb_vga_text_reader;

    localparam int HV = 64, HF = 8, HS = 16, HB = 8;
    localparam int VV = 48, VF = 3, VS = 2, VB = 4;
    localparam int HT = HV + HF + HS + HB;   // 96
    localparam int VT = VV + VF + VS + VB;   // 57
    localparam int FRAME = HT * VT;          // 5472

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] vram_read_address;
    logic [7:0]  r_data = 8'h00;
    logic        hsync, vsync, de, frame_start;
    logic [11:0] rgb;

    logic [7:0]  vram [4096];
    int          m = 0;
    bit          have_reset = 1'b0;
    int          checks = 0;
    int          errors = 0;

    vga_text_reader #(
        .READ_ADDR_SIZE (12),
        .H_VISIBLE      (HV),
        .H_FRONT        (HF),
        .H_SYNC         (HS),
        .H_BACK         (HB),
        .V_VISIBLE      (VV),
        .V_FRONT        (VF),
        .V_SYNC         (VS),
        .V_BACK         (VB),
        .FG_COLOR       (12'hFFF),
        .BG_COLOR       (12'h000)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .vram_read_address (vram_read_address),
        .r_data            (r_data),
        .hsync             (hsync),
        .vsync             (vsync),
        .de                (de),
        .rgb               (rgb),
        .frame_start       (frame_start)
`ifdef VGA_TEXT_CURSOR_EN
        ,
        .cursor_col        (7'd0),
        .cursor_row        (5'd0)
`endif
    );

    always #5 clk = ~clk;

    // VRAM model: answers the presented address on the falling edge.
    always @(negedge clk) r_data = vram[vram_read_address];

    // Cycles since the last reset edge.
    always @(posedge clk) begin
        if (rst) begin
            m = 0;
            have_reset = 1'b1;
        end else if (have_reset) begin
            m = m + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at t=%0t m=%0d", name, act, exp, $time, m);
        end
    endtask

    function automatic int mfont(input int code, input int line);
        int a_glyph [16] = '{8'h18, 8'h3C, 8'h66, 8'h66, 8'h7E, 8'h66, 8'h66, 8'h66,
                             0, 0, 0, 0, 0, 0, 0, 0};
        if (code == 65) return a_glyph[line];
        return (code + 17 * line) % 256;
    endfunction

    function automatic int exp_addr(input int n);
        int h, v;
        h = n % HT;
        v = (n / HT) % VT;
        if (h < HV && v < VV) return (v / 16) * 128 + h / 8;
        return 0;
    endfunction

    // Expected registered outputs for raster position n.
    task automatic model(input int n, output logic e_hs, output logic e_vs,
                         output logic e_de, output logic e_fs, output logic [11:0] e_rgb);
        int h, v, fb;
        h = n % HT;
        v = (n / HT) % VT;
        e_de  = (h < HV) && (v < VV);
        e_hs  = !(h >= HV + HF && h < HV + HF + HS);
        e_vs  = !(v >= VV + VF && v < VV + VF + VS);
        e_fs  = (n % FRAME) == 0;
        e_rgb = 12'h000;
        if (e_de) begin
            fb = mfont(int'(vram[(v / 16) * 128 + h / 8]), v % 16);
            if (((fb >> (7 - h % 8)) & 1) == 1) e_rgb = 12'hFFF;
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        logic e_hs, e_vs, e_de, e_fs;
        logic [11:0] e_rgb;
        if (have_reset) begin
            chk("addr", 32'(vram_read_address), (m >= 1) ? 32'(exp_addr(m - 1)) : 32'd0);
            if (m >= 3) begin
                model(m - 3, e_hs, e_vs, e_de, e_fs, e_rgb);
            end else begin
                e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_fs = 1'b0; e_rgb = 12'h000;
            end
            chk("hsync", 32'(hsync), 32'(e_hs));
            chk("vsync", 32'(vsync), 32'(e_vs));
            chk("de", 32'(de), 32'(e_de));
            chk("frame_start", 32'(frame_start), 32'(e_fs));
            chk("rgb", 32'(rgb), 32'(e_rgb));
        end
    end

    initial begin
        logic [11:0] a_row [8] = '{12'h000, 12'h000, 12'h000, 12'hFFF,
                                   12'hFFF, 12'h000, 12'h000, 12'h000};
        for (int i = 0; i < 4096; i++) vram[i] = 8'($urandom);
        vram[0] = 8'h41;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Two full frames plus a partial one, pinning key points literally.
        for (int i = 1; i <= 2 * FRAME + 20 * HT + 30; i++) begin
            @(negedge clk);
            if (i == 1)    chk("lit_addr_0", 32'(vram_read_address), 32'h000);
            if (i == 8)    chk("lit_addr_h7", 32'(vram_read_address), 32'h000);
            if (i == 9)    chk("lit_addr_h8", 32'(vram_read_address), 32'h001);
            if (i == 64)   chk("lit_addr_h63", 32'(vram_read_address), 32'h007);
            if (i == 66)   chk("lit_addr_blank", 32'(vram_read_address), 32'h000);
            if (i == 1537) chk("lit_addr_v16", 32'(vram_read_address), 32'h080);
            if (i >= 3 && i <= 10) begin
                chk("lit_glyph_A", 32'(rgb), 32'(a_row[i - 3]));
                chk("lit_glyph_de", 32'(de), 32'd1);
            end
            if (i == 3)    chk("lit_fs_first", 32'(frame_start), 32'd1);
            if (i == 4)    chk("lit_fs_after", 32'(frame_start), 32'd0);
            if (i == 74)   chk("lit_hs_before", 32'(hsync), 32'd1);
            if (i == 75)   chk("lit_hs_start", 32'(hsync), 32'd0);
            if (i == 90)   chk("lit_hs_last", 32'(hsync), 32'd0);
            if (i == 91)   chk("lit_hs_end", 32'(hsync), 32'd1);
            if (i == 4898) chk("lit_vs_before", 32'(vsync), 32'd1);
            if (i == 4899) chk("lit_vs_start", 32'(vsync), 32'd0);
            if (i == 5090) chk("lit_vs_last", 32'(vsync), 32'd0);
            if (i == 5091) chk("lit_vs_end", 32'(vsync), 32'd1);
            if (i == 3 + FRAME) chk("lit_fs_period", 32'(frame_start), 32'd1);
        end

        // Mid-frame reset at h=30, v=20 while pixels are visible.
        chk("lit_de_before_rst", 32'(de), 32'd1);
        rst = 1'b1;
        for (int i = 0; i < 4096; i++) vram[i] = 8'hFF;
        @(negedge clk);
        chk("lit_rst_hsync", 32'(hsync), 32'd1);
        chk("lit_rst_vsync", 32'(vsync), 32'd1);
        chk("lit_rst_de", 32'(de), 32'd0);
        chk("lit_rst_rgb", 32'(rgb), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= FRAME + 600; i++) begin
            @(negedge clk);
            if (i == 2) chk("lit_rst_fs_early", 32'(frame_start), 32'd0);
            if (i == 3) chk("lit_rst_fs", 32'(frame_start), 32'd1);
            if (i == 3) chk("lit_ff_pixel0", 32'(rgb), 32'hFFF);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
